// File: rtl/tx_arb_pkg.sv
// Shared types and constants for tx_stream_arbiter: state encoding, beat payload and header packing.
package tx_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_HDR  = 2'd1;
    localparam arb_state_t ARB_PASS = 2'd2;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } tx_beat_t;

    // Header word: magic byte, source index byte, completed-packet count.
    function automatic logic [DATA_W-1:0] pack_hdr(input logic [7:0] src, input logic [CNT_W-1:0] cnt);
        return {HDR_MAGIC, src, cnt};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; the search starts one past i_ptr and wraps modulo N.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] i_valid,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_hit
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_hit    = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!o_hit && i_valid[k] && (((32'(i_ptr) + off) % N) == k)) begin
                    o_hit       = 1'b1;
                    o_onehot[k] = 1'b1;
                    o_idx       = W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: packet-locked round-robin mux of NSRC AXI-stream sources onto one registered master.
// Define TX_ARB_HEADER_EN to prefix every packet with a {A5, src, pkt_cnt} header word.
module tx_stream_arbiter
    import tx_arb_pkg::*;
#(
    parameter int unsigned NSRC = 4,
    parameter int unsigned SRCW = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NSRC-1:0]        s_tvalid,
    output logic [NSRC-1:0]        s_tready,
    input  logic [DATA_W*NSRC-1:0] s_tdata,
    input  logic [KEEP_W*NSRC-1:0] s_tkeep,
    input  logic [NSRC-1:0]        s_tlast,
    input  logic                   o_tready,
    output logic                   o_tvalid,
    output logic [DATA_W-1:0]      o_tdata,
    output logic [KEEP_W-1:0]      o_tkeep,
    output logic                   o_tlast,
    output logic [NSRC-1:0]        o_grant,
    output logic [CNT_W-1:0]       o_pkt_cnt
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [NSRC-1:0] r_grant;
    logic [SRCW-1:0] r_gidx;
    logic [SRCW-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic            r_tvalid;
    tx_beat_t        r_out;

    logic [NSRC-1:0] w_pick_onehot;
    logic [SRCW-1:0] w_pick_idx;
    logic            w_pick_hit;
    logic            w_out_free;
    logic            w_src_valid;
    tx_beat_t        w_src_beat;
    logic            w_pass_rdy;
    logic            w_hdr_load;
    logic            w_beat_acc;
    logic            w_pkt_done;

    rr_pick #(
        .N (NSRC),
        .W (SRCW)
    ) u_pick (
        .i_valid  (s_tvalid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_hit    (w_pick_hit)
    );

    // Output register can take a new word when empty or being drained this cycle.
    assign w_out_free = ~r_tvalid | o_tready;

    // Granted-source mux, one-hot select.
    always_comb begin
        w_src_valid = 1'b0;
        w_src_beat  = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (r_grant[k]) begin
                w_src_valid     = s_tvalid[k];
                w_src_beat.data = s_tdata[DATA_W*k +: DATA_W];
                w_src_beat.keep = s_tkeep[KEEP_W*k +: KEEP_W];
                w_src_beat.last = s_tlast[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_hit) begin
`ifdef TX_ARB_HEADER_EN
                    w_state_nxt = ARB_HDR;
`else
                    w_state_nxt = ARB_PASS;
`endif
                end
            end
`ifdef TX_ARB_HEADER_EN
            ARB_HDR: begin
                if (w_out_free) begin
                    w_state_nxt = ARB_PASS;
                end
            end
`endif
            ARB_PASS: begin
                if (w_pkt_done) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_pass_rdy = 1'b0;
        w_hdr_load = 1'b0;
        case (r_state)
            ARB_PASS: w_pass_rdy = w_out_free;
`ifdef TX_ARB_HEADER_EN
            ARB_HDR:  w_hdr_load = w_out_free;
`endif
            default: ;
        endcase
    end

    assign s_tready   = r_grant & {NSRC{w_pass_rdy}};
    assign w_beat_acc = w_pass_rdy & w_src_valid;
    assign w_pkt_done = w_beat_acc & w_src_beat.last;

    // Grant is held from pick to the accepted tlast beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= SRCW'(NSRC - 1);
            r_pkt_cnt <= '0;
        end else if ((r_state == ARB_IDLE) && w_pick_hit) begin
            r_grant <= w_pick_onehot;
            r_gidx  <= w_pick_idx;
        end else if (w_pkt_done) begin
            r_grant   <= '0;
            r_rr_ptr  <= r_gidx;
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tvalid <= 1'b0;
            r_out    <= '0;
        end else if (w_hdr_load) begin
            r_tvalid   <= 1'b1;
            r_out.data <= pack_hdr(8'(r_gidx), r_pkt_cnt);
            r_out.keep <= '1;
            r_out.last <= 1'b0;
        end else if (w_beat_acc) begin
            r_tvalid <= 1'b1;
            r_out    <= w_src_beat;
        end else if (o_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign o_tvalid  = r_tvalid;
    assign o_tdata   = r_out.data;
    assign o_tkeep   = r_out.keep;
    assign o_tlast   = r_out.last;
    assign o_grant   = r_grant;
    assign o_pkt_cnt = r_pkt_cnt;

endmodule
